// File: rtl/aes_round_sched_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_KEY_W   = 128;
  localparam int AES_KEY_LAT = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/aes_round_sched_key_cache.sv
// Remembers the last fully expanded cipher key so repeated keys skip expansion.
module aes_key_cache
  import aes_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 store,
  input  logic [AES_KEY_W-1:0] store_key,
  input  logic [AES_KEY_W-1:0] cmp_key,
  output logic                 hit
);

  logic [AES_KEY_W-1:0] cached_key;
  logic                 key_vld;

  // A flush in the same cycle as a store must leave the cache invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_vld <= 1'b0;
    end else if (flush) begin
      key_vld <= 1'b0;
    end else if (store) begin
      key_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      cached_key <= store_key;
    end
  end

  assign hit = key_vld && (cached_key == cmp_key) && !flush;

endmodule

// File: rtl/aes_round_sched.sv
// Control sequencer for the AES-128 core: key expansion on miss, then INIT, rounds and final round.
module aes_round_sched
  import aes_ctrl_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int KEY_LAT = AES_KEY_LAT
) (
  input  logic                 HCLK,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_KEY_W-1:0] in_key,
  input  logic                 flush,
  output logic                 key_ena,
  output logic [AES_KEY_W-1:0] key_word,
  output logic                 rnd_load,
  output logic                 rnd_en,
  output logic                 last_rnd,
  output logic [3:0]           rnd_idx,
  output logic [3:0]           key_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CNT_W = $clog2(KEY_LAT + 1);

  sched_state_t state, state_nxt;
  logic [CNT_W-1:0] key_cnt;
  logic             accept;
  logic             hit;
  logic             key_done;

  assign accept   = in_valid && in_ready;
  assign key_done = (state == S_KEYEXP) && (key_cnt == CNT_W'(KEY_LAT - 1));

  aes_key_cache u_cache (
    .clk       (HCLK),
    .rst       (rst),
    .flush     (flush),
    .store     (key_done),
    .store_key (key_word),
    .cmp_key   (in_key),
    .hit       (hit)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    key_ena   = 1'b0;
    rnd_load  = 1'b0;
    rnd_en    = 1'b0;
    last_rnd  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = hit ? S_INIT : S_KEYEXP;
      end
      S_KEYEXP: begin
        key_ena = 1'b1;
        if (key_done) state_nxt = S_INIT;
      end
      S_INIT: begin
        rnd_load  = 1'b1;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        if (rnd_idx == 4'(NR - 1)) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        rnd_en    = 1'b1;
        last_rnd  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Round index doubles as the subkey select: 0 = raw key, k = subkey(k-1).
  always_ff @(posedge HCLK) begin
    if (rst) begin
      state    <= S_IDLE;
      key_cnt  <= '0;
      rnd_idx  <= 4'd0;
      key_word <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            key_word <= in_key;
            rnd_idx  <= 4'd0;
            key_cnt  <= '0;
          end
        end
        S_KEYEXP: key_cnt <= key_cnt + CNT_W'(1);
        S_INIT:   rnd_idx <= 4'd1;
        S_ROUND:  rnd_idx <= rnd_idx + 4'd1;
        default: ;
      endcase
    end
  end

  assign key_sel = rnd_idx;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: miss/hit paths, flush, DONE back-pressure, mid-block reset.
module tb_aes_round_sched;

  logic         HCLK = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic         flush;
  logic         key_ena;
  logic [127:0] key_word;
  logic         rnd_load;
  logic         rnd_en;
  logic         last_rnd;
  logic [3:0]   rnd_idx;
  logic [3:0]   key_sel;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_round_sched dut (
    .HCLK      (HCLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .flush     (flush),
    .key_ena   (key_ena),
    .key_word  (key_word),
    .rnd_load  (rnd_load),
    .rnd_en    (rnd_en),
    .last_rnd  (last_rnd),
    .rnd_idx   (rnd_idx),
    .key_sel   (key_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Accepts one request and walks its whole schedule, checking every cycle.
  task automatic run_block(input logic [127:0] key, input bit miss, input int hold, input bit fl);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_key    = key;
    flush     = fl;
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    if (miss) begin
      for (int i = 0; i < 12; i++) begin
        check("keyexp_ena", key_ena, 1);
        check("keyexp_word", key_word, key);
        check("keyexp_busy", busy, 1);
        step();
      end
    end
    check("init_no_keyena", key_ena, 0);
    check("init_load", rnd_load, 1);
    check("init_idx", rnd_idx, 0);
    check("init_sel", key_sel, 0);
    check("init_word", key_word, key);
    step();
    for (int k = 1; k <= 9; k++) begin
      check("round_en", rnd_en, 1);
      check("round_sel", key_sel, 128'(k));
      check("round_last", last_rnd, 0);
      check("round_outv", out_valid, 0);
      step();
    end
    check("final_en", rnd_en, 1);
    check("final_last", last_rnd, 1);
    check("final_sel", key_sel, 10);
    step();
    check("done_outv", out_valid, 1);
    check("done_inrdy", in_ready, 0);
    check("done_nornd", rnd_en, 0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_outv", out_valid, 1);
      check("hold_inrdy", in_ready, 0);
      check("hold_idx", rnd_idx, 10);
    end
    out_ready = 1'b1;
    step();
    check("idle_inrdy", in_ready, 1);
    check("idle_outv", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_keyena", key_ena, 0);
    check("rst_word", key_word, 0);
    check("rst_load", rnd_load, 0);
    check("rst_en", rnd_en, 0);
    check("rst_last", last_rnd, 0);
    check("rst_idx", rnd_idx, 0);
    check("rst_sel", key_sel, 0);
    check("rst_outv", out_valid, 0);
    check("rst_busy", busy, 0);

    rst = 1'b0;
    step();
    step();
    check("rel_inrdy", in_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_keyena", key_ena, 0);

    // Cold key misses, then the same key hits.
    run_block(KEY_A, 1'b1, 0, 1'b0);
    run_block(KEY_A, 1'b0, 0, 1'b0);

    // New key misses; flush pulse forces the following identical key to miss.
    run_block(KEY_B, 1'b1, 0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_block(KEY_B, 1'b1, 0, 1'b0);

    // Flush coincident with accept is a miss; then a hit with DONE back-pressure.
    run_block(KEY_B, 1'b1, 0, 1'b1);
    run_block(KEY_B, 1'b0, 5, 1'b0);

    // Reset in ROUND at rnd_idx 4 abandons the block and invalidates the cache.
    in_valid = 1'b1;
    in_key   = KEY_B;
    step();
    in_valid = 1'b0;
    check("mid_init", rnd_load, 1);
    for (int i = 0; i < 4; i++) step();
    check("mid_idx4", rnd_idx, 4);
    check("mid_en", rnd_en, 1);
    rst = 1'b1;
    step();
    check("mrst_en", rnd_en, 0);
    check("mrst_idx", rnd_idx, 0);
    check("mrst_word", key_word, 0);
    check("mrst_outv", out_valid, 0);
    check("mrst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("mrst_outv2", out_valid, 0);
    run_block(KEY_B, 1'b1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
